// File: rtl/exp_table_store.sv
// Captures the exp(x*sigma) generator stream into RAM and checks it, then serves x-indexed lookups.
// Latency: a lookup response appears 2 cycles after its accept edge; 1 request/cycle throughput.
// Backpressure: requests are held off (oReqReady=0) outside READY; responses are never stalled.
module exp_table_store #(
   parameter int X_MIN  = -307,
   parameter int X_MAX  = 280,
   parameter int ADDR_W = 10,
   parameter int DATA_W = 18
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iLoad,
   output logic              oStart,
   input  logic [DATA_W-1:0] iWrData,
   input  logic [ADDR_W-1:0] iWrAddr,
   input  logic              iWrValid,
   input  logic              iWrDone,
   output logic              oTableReady,
   output logic              oError,
   input  logic              iReqValid,
   input  logic [ADDR_W-1:0] iReqAddr,
   output logic              oReqReady,
   output logic              oRespValid,
   output logic [DATA_W-1:0] oRespData,
   output logic [ADDR_W-1:0] oRespAddr,
   output logic              oRespHit
);

   localparam int DEPTH = X_MAX - X_MIN + 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] XMIN_A  = ADDR_W'(X_MIN);
   localparam logic [ADDR_W-1:0] XMAX_A  = ADDR_W'(X_MAX);
   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_READY} state_t;

   state_t            state;
   logic [CNT_W-1:0]  wr_cnt;
   logic [ADDR_W-1:0] exp_addr;
   logic [DATA_W-1:0] ram [DEPTH];
   logic [DATA_W-1:0] ram_q;

   logic              wr_ok;
   logic              wr_bad;
   logic              fill_good;
   logic [CNT_W-1:0]  cnt_after;
   logic [ADDR_W-1:0] wr_idx;

   logic              req_acc;
   logic              req_hit;
   logic              s1_vld;
   logic              s1_hit;
   logic [ADDR_W-1:0] s1_addr;
   logic [ADDR_W-1:0] s1_idx;
   logic              s2_vld;
   logic              s2_hit;
   logic [ADDR_W-1:0] s2_addr;

   // A write is only taken when it is exactly the next expected x; anything else poisons the fill.
   assign wr_ok     = (state == S_FILL) && iWrValid && (iWrAddr == exp_addr) && (wr_cnt < DEPTH_C);
   assign wr_bad    = (state == S_FILL) && iWrValid && !wr_ok;
   assign cnt_after = wr_cnt + CNT_W'(wr_ok);
   assign fill_good = (cnt_after == DEPTH_C) && !oError && !wr_bad;
   assign wr_idx    = iWrAddr - XMIN_A;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= S_IDLE;
         oStart      <= 1'b0;
         oTableReady <= 1'b0;
         oReqReady   <= 1'b0;
         oError      <= 1'b0;
         wr_cnt      <= '0;
         exp_addr    <= XMIN_A;
      end else begin
         oStart <= 1'b0;
         case (state)
            S_IDLE: begin
               if (iLoad) begin
                  oStart   <= 1'b1;
                  oError   <= 1'b0;
                  wr_cnt   <= '0;
                  exp_addr <= XMIN_A;
                  state    <= S_FILL;
               end
            end
            S_FILL: begin
               if (wr_ok) begin
                  wr_cnt   <= cnt_after;
                  exp_addr <= exp_addr + ADDR_W'(1);
               end
               if (wr_bad)
                  oError <= 1'b1;
               if (iWrDone) begin
                  if (fill_good) begin
                     state       <= S_READY;
                     oTableReady <= 1'b1;
                     oReqReady   <= 1'b1;
                  end else begin
                     state  <= S_IDLE;
                     oError <= 1'b1;
                  end
               end
            end
            S_READY: begin
               if (iLoad) begin
                  oStart      <= 1'b1;
                  oError      <= 1'b0;
                  oTableReady <= 1'b0;
                  oReqReady   <= 1'b0;
                  wr_cnt      <= '0;
                  exp_addr    <= XMIN_A;
                  state       <= S_FILL;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign req_acc = iReqValid && oReqReady;
   assign req_hit = ($signed(iReqAddr) >= $signed(XMIN_A)) && ($signed(iReqAddr) <= $signed(XMAX_A));

   // RAM is never reset; out-of-range lookups skip the read entirely.
   always_ff @(posedge CLK) begin
      if (wr_ok)
         ram[wr_idx] <= iWrData;
      if (s1_hit)
         ram_q <= ram[s1_idx];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s1_vld     <= 1'b0;
         s1_hit     <= 1'b0;
         s1_addr    <= '0;
         s1_idx     <= '0;
         s2_vld     <= 1'b0;
         s2_hit     <= 1'b0;
         s2_addr    <= '0;
         oRespValid <= 1'b0;
         oRespHit   <= 1'b0;
         oRespData  <= '0;
         oRespAddr  <= '0;
      end else begin
         s1_vld     <= req_acc;
         s1_hit     <= req_acc && req_hit;
         s1_addr    <= iReqAddr;
         s1_idx     <= iReqAddr - XMIN_A;
         s2_vld     <= s1_vld;
         s2_hit     <= s1_vld && s1_hit;
         s2_addr    <= s1_addr;
         oRespValid <= s2_vld;
         oRespHit   <= s2_hit;
         oRespData  <= s2_hit ? ram_q : '0;
         oRespAddr  <= s2_vld ? s2_addr : '0;
      end
   end

endmodule
